// File: rtl/rv32_csr_pkg.sv
// Shared encodings for the Zicsr access unit: funct3 values, privilege levels,
// FSM states and the write-value helper.
package rv32_csr_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  // csr_addr[11:10] value marking a read-only CSR
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_RWAIT = 2'd2,
    ST_WRITE = 2'd3
  } csr_state_e;

  // funct3[1:0] selects the operation independent of the immediate form
  function automatic logic [31:0] csr_new_value(input logic [1:0]  op,
                                                input logic [31:0] old_val,
                                                input logic [31:0] src_val);
    logic [31:0] res;
    case (op)
      2'b01:   res = src_val;
      2'b10:   res = old_val | src_val;
      2'b11:   res = old_val & ~src_val;
      default: res = old_val;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] csr_tval(input logic [2:0]  funct3,
                                           input logic [11:0] addr);
    return {17'd0, funct3, addr};
  endfunction

endpackage

// File: rtl/rv32_csr_access_unit_legality.sv
// Combinational legality check for a Zicsr instruction: decodes whether it writes
// the CSR and whether it must trap as illegal.
module rv32_csr_legality_check
  import rv32_csr_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [11:0] addr,
  input  logic [4:0]  rs1_idx,
  input  logic [1:0]  priviledge,
  output logic        illegal,
  output logic        write_req
);

  logic bad_op_s;
  logic priv_fail_s;
  logic ro_fail_s;

  // Decode write intent and reject undefined funct3 encodings
  always_comb begin
    write_req = 1'b0;
    bad_op_s  = 1'b0;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: write_req = 1'b1;
      F3_CSRRS, F3_CSRRC, F3_CSRRSI, F3_CSRRCI: write_req = (rs1_idx != 5'd0);
      default: bad_op_s = 1'b1;
    endcase
  end

  // Privilege and read-only checks
  always_comb begin
    priv_fail_s = (addr[9:8] > priviledge);
    ro_fail_s   = (addr[11:10] == CSR_RO_FIELD) && write_req;
    illegal     = bad_op_s | priv_fail_s | ro_fail_s;
  end

endmodule

// File: rtl/rv32_csr_access_unit.sv
// Zicsr initiator: accepts one CSR instruction at a time, checks legality, reads the
// old value, writes the updated value and returns the old value for rd write-back.
module rv32_csr_access_unit
  import rv32_csr_pkg::*;
#(
  parameter bit SYNC_READ = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  priviledge,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr_addr,
  input  logic [4:0]  req_rs1_idx,
  input  logic [31:0] req_rs1_data,
  input  logic [4:0]  req_rd_idx,
  output logic [11:0] csr_addr,
  output logic        csr_re,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [31:0] csr_wdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_idx,
  output logic [31:0] wb_data,
  output logic        exc_illegal,
  output logic [31:0] exc_tval
);

  csr_state_e  state_r;
  csr_state_e  next_state_s;
  logic [2:0]  funct3_r;
  logic [11:0] addr_r;
  logic [4:0]  rs1_idx_r;
  logic [31:0] rs1_data_r;
  logic [4:0]  rd_idx_r;
  logic [31:0] old_r;

  logic        illegal_s;
  logic        write_req_s;
  logic        read_en_s;
  logic        capture_s;
  logic [31:0] src_s;
  logic [31:0] new_val_s;

  rv32_csr_legality_check u_legality (
    .funct3     (funct3_r),
    .addr       (addr_r),
    .rs1_idx    (rs1_idx_r),
    .priviledge (priviledge),
    .illegal    (illegal_s),
    .write_req  (write_req_s)
  );

  // Operand selection and old-value capture point
  always_comb begin
    // CSRRW/CSRRWI with rd = x0 must not have a read side-effect
    read_en_s = !((funct3_r[1:0] == 2'b01) && (rd_idx_r == 5'd0));
    src_s     = funct3_r[2] ? {27'd0, rs1_idx_r} : rs1_data_r;
    new_val_s = csr_new_value(funct3_r[1:0], old_r, src_s);
    if (SYNC_READ) begin
      capture_s = (state_r == ST_RWAIT);
    end else begin
      capture_s = (state_r == ST_READ) && !illegal_s;
    end
  end

  // State register, request latch and old-value capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      funct3_r   <= 3'd0;
      addr_r     <= 12'd0;
      rs1_idx_r  <= 5'd0;
      rs1_data_r <= 32'd0;
      rd_idx_r   <= 5'd0;
      old_r      <= 32'd0;
    end else begin
      state_r <= next_state_s;
      if (req_valid && (state_r == ST_IDLE)) begin
        funct3_r   <= req_funct3;
        addr_r     <= req_csr_addr;
        rs1_idx_r  <= req_rs1_idx;
        rs1_data_r <= req_rs1_data;
        rd_idx_r   <= req_rd_idx;
      end
      if (capture_s) begin
        old_r <= read_en_s ? csr_rdata : 32'd0;
      end
    end
  end

  // Next-state and output decode; strobes only in their owning state
  always_comb begin
    next_state_s = state_r;
    req_ready    = 1'b0;
    csr_addr     = 12'd0;
    csr_re       = 1'b0;
    csr_we       = 1'b0;
    csr_wdata    = 32'd0;
    wb_valid     = 1'b0;
    wb_rd_idx    = 5'd0;
    wb_data      = 32'd0;
    exc_illegal  = 1'b0;
    exc_tval     = 32'd0;
    case (state_r)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state_s = ST_READ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (illegal_s) begin
          exc_illegal  = 1'b1;
          exc_tval     = csr_tval(funct3_r, addr_r);
          next_state_s = ST_IDLE;
        end else begin
          csr_addr     = addr_r;
          csr_re       = read_en_s;
          next_state_s = SYNC_READ ? ST_RWAIT : ST_WRITE;
        end
      end
      ST_RWAIT: begin
        csr_addr     = addr_r;
        next_state_s = ST_WRITE;
      end
      ST_WRITE: begin
        csr_addr     = addr_r;
        csr_we       = write_req_s;
        csr_wdata    = write_req_s ? new_val_s : 32'd0;
        wb_valid     = (rd_idx_r != 5'd0);
        wb_rd_idx    = wb_valid ? rd_idx_r : 5'd0;
        wb_data      = wb_valid ? old_r : 32'd0;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rv32_csr_access_unit.sv
// Self-checking bench: two instances (combinational and registered CSR read) share one
// behavioural CSR file; each instruction is checked cycle by cycle against a rule model.
module tb_rv32_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  priviledge = 2'd3;
  logic        req_valid0 = 1'b0;
  logic        req_valid1 = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [11:0] req_csr_addr = 12'd0;
  logic [4:0]  req_rs1_idx = 5'd0;
  logic [31:0] req_rs1_data = 32'd0;
  logic [4:0]  req_rd_idx = 5'd0;

  logic        r0_ready, r1_ready, r0_re, r1_re, r0_we, r1_we;
  logic        r0_wb, r1_wb, r0_exc, r1_exc;
  logic [11:0] r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata, r0_wbd, r1_wbd, r0_tval, r1_tval;
  logic [4:0]  r0_wbrd, r1_wbrd;
  logic [31:0] rdata0, rdata1;

  logic [31:0] csr_mem [0:4095];
  logic        init_en = 1'b0;
  logic        preset_en = 1'b0;
  logic [11:0] preset_addr = 12'd0;
  logic [31:0] preset_val = 32'd0;

  logic        sel = 1'b0;
  logic        o_ready, o_re, o_we, o_wb, o_exc;
  logic [11:0] o_addr;
  logic [31:0] o_wdata, o_wbd, o_tval;
  logic [4:0]  o_wbrd;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rv32_csr_access_unit #(.SYNC_READ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .priviledge(priviledge),
    .req_valid(req_valid0), .req_ready(r0_ready), .req_funct3(req_funct3),
    .req_csr_addr(req_csr_addr), .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
    .req_rd_idx(req_rd_idx), .csr_addr(r0_addr), .csr_re(r0_re), .csr_rdata(rdata0),
    .csr_we(r0_we), .csr_wdata(r0_wdata), .wb_valid(r0_wb), .wb_rd_idx(r0_wbrd),
    .wb_data(r0_wbd), .exc_illegal(r0_exc), .exc_tval(r0_tval)
  );

  rv32_csr_access_unit #(.SYNC_READ(1'b1)) dut1 (
    .clk(clk), .rst(rst), .priviledge(priviledge),
    .req_valid(req_valid1), .req_ready(r1_ready), .req_funct3(req_funct3),
    .req_csr_addr(req_csr_addr), .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
    .req_rd_idx(req_rd_idx), .csr_addr(r1_addr), .csr_re(r1_re), .csr_rdata(rdata1),
    .csr_we(r1_we), .csr_wdata(r1_wdata), .wb_valid(r1_wb), .wb_rd_idx(r1_wbrd),
    .wb_data(r1_wbd), .exc_illegal(r1_exc), .exc_tval(r1_tval)
  );

  // Behavioural CSR file: combinational read for dut0, registered read for dut1
  assign rdata0 = csr_mem[r0_addr];
  always @(posedge clk) begin
    if (r1_re) rdata1 <= csr_mem[r1_addr];
    if (init_en) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= $urandom;
    end else if (r0_we) begin
      csr_mem[r0_addr] <= r0_wdata;
    end else if (r1_we) begin
      csr_mem[r1_addr] <= r1_wdata;
    end else if (preset_en) begin
      csr_mem[preset_addr] <= preset_val;
    end
  end

  always_comb begin
    o_ready = sel ? r1_ready : r0_ready;
    o_re    = sel ? r1_re    : r0_re;
    o_we    = sel ? r1_we    : r0_we;
    o_wb    = sel ? r1_wb    : r0_wb;
    o_exc   = sel ? r1_exc   : r0_exc;
    o_addr  = sel ? r1_addr  : r0_addr;
    o_wdata = sel ? r1_wdata : r0_wdata;
    o_wbd   = sel ? r1_wbd   : r0_wbd;
    o_tval  = sel ? r1_tval  : r0_tval;
    o_wbrd  = sel ? r1_wbrd  : r0_wbrd;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preset(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    preset_en = 1'b1; preset_addr = a; preset_val = v;
    @(negedge clk);
    preset_en = 1'b0;
  endtask

  // Issue one instruction and check every cycle until the unit is idle again
  task automatic run_op(input bit sync, input logic [1:0] priv, input logic [2:0] f3,
                        input logic [11:0] addr, input logic [4:0] rs1,
                        input logic [31:0] rs1d, input logic [4:0] rd, input string tag);
    logic wreq, illegal, rd_side;
    logic [31:0] old, src, newv, tval;
    int wc, last;
    logic e_ready, e_re, e_we, e_wb, e_exc;
    wreq    = (f3 == 3'd1) || (f3 == 3'd5) || (rs1 != 5'd0);
    illegal = (f3 == 3'd0) || (f3 == 3'd4) || (int'(addr[9:8]) > int'(priv)) ||
              ((addr[11:10] == 2'b11) && wreq);
    rd_side = !illegal && !(((f3 == 3'd1) || (f3 == 3'd5)) && (rd == 5'd0));
    old     = rd_side ? csr_mem[addr] : 32'd0;
    src     = (f3 >= 3'd4) ? {27'd0, rs1} : rs1d;
    if (f3 == 3'd1 || f3 == 3'd5)      newv = src;
    else if (f3 == 3'd2 || f3 == 3'd6) newv = old | src;
    else                               newv = old & ~src;
    tval = {17'd0, f3, addr};
    wc   = sync ? 3 : 2;
    last = illegal ? 2 : wc + 1;

    sel = sync;
    @(negedge clk);
    priviledge = priv; req_funct3 = f3; req_csr_addr = addr;
    req_rs1_idx = rs1; req_rs1_data = rs1d; req_rd_idx = rd;
    if (sync) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    compared++;
    if (o_ready !== 1'b1) begin
      mismatched++; $display("FAIL %s ready_before_accept: got %b want 1", tag, o_ready);
    end
    @(posedge clk); #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      e_ready = (c == last);
      e_exc   = illegal && (c == 1);
      e_re    = rd_side && (c == 1);
      e_we    = !illegal && (c == wc) && wreq;
      e_wb    = !illegal && (c == wc) && (rd != 5'd0);
      compared += 5;
      if (o_ready !== e_ready) begin
        mismatched++; $display("FAIL %s ready c%0d: got %b want %b", tag, c, o_ready, e_ready);
      end
      if (o_exc !== e_exc) begin
        mismatched++; $display("FAIL %s exc c%0d: got %b want %b", tag, c, o_exc, e_exc);
      end
      if (o_re !== e_re) begin
        mismatched++; $display("FAIL %s csr_re c%0d: got %b want %b", tag, c, o_re, e_re);
      end
      if (o_we !== e_we) begin
        mismatched++; $display("FAIL %s csr_we c%0d: got %b want %b", tag, c, o_we, e_we);
      end
      if (o_wb !== e_wb) begin
        mismatched++; $display("FAIL %s wb_valid c%0d: got %b want %b", tag, c, o_wb, e_wb);
      end
      if (e_exc) begin
        compared++;
        if (o_tval !== tval) begin
          mismatched++; $display("FAIL %s tval: got %h want %h", tag, o_tval, tval);
        end
      end
      if (e_re || e_we) begin
        compared++;
        if (o_addr !== addr) begin
          mismatched++; $display("FAIL %s csr_addr c%0d: got %h want %h", tag, c, o_addr, addr);
        end
      end
      if (e_we) begin
        compared++;
        if (o_wdata !== newv) begin
          mismatched++; $display("FAIL %s wdata: got %h want %h", tag, o_wdata, newv);
        end
      end
      if (e_wb) begin
        compared += 2;
        if (o_wbrd !== rd) begin
          mismatched++; $display("FAIL %s wb_rd: got %0d want %0d", tag, o_wbrd, rd);
        end
        if (o_wbd !== old) begin
          mismatched++; $display("FAIL %s wb_data: got %h want %h", tag, o_wbd, old);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); init_en = 1'b1;
    @(negedge clk); init_en = 1'b0;
    @(negedge clk);
    compared += 4;
    if ({r0_ready, r1_ready} !== 2'b11) begin
      mismatched++; $display("FAIL reset_ready: got %b want 11", {r0_ready, r1_ready});
    end
    if ({r0_re, r0_we, r0_wb, r0_exc, r1_re, r1_we, r1_wb, r1_exc} !== 8'd0) begin
      mismatched++; $display("FAIL reset_strobes: got %b want 0",
                             {r0_re, r0_we, r0_wb, r0_exc, r1_re, r1_we, r1_wb, r1_exc});
    end
    if ({r0_addr, r0_wdata, r0_wbd, r0_tval, r0_wbrd} !== 113'd0) begin
      mismatched++; $display("FAIL reset_data0: nonzero output bus");
    end
    if ({r1_addr, r1_wdata, r1_wbd, r1_tval, r1_wbrd} !== 113'd0) begin
      mismatched++; $display("FAIL reset_data1: nonzero output bus");
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    preset(12'h340, 32'h12345678);
    run_op(1'b0, 2'd3, 3'b001, 12'h340, 5'd7, 32'hDEADBEEF, 5'd5, "rw_340");
    preset(12'h300, 32'h00001888);
    run_op(1'b0, 2'd3, 3'b010, 12'h300, 5'd0, 32'hFFFF0000, 5'd3, "rs_x0");
    run_op(1'b0, 2'd3, 3'b111, 12'h300, 5'd8, 32'h0, 5'd0, "rci_8");
    compared++;
    @(negedge clk);
    if (csr_mem[12'h300] !== 32'h00001880) begin
      mismatched++; $display("FAIL rci_result: got %h want 00001880", csr_mem[12'h300]);
    end
    run_op(1'b0, 2'd0, 3'b010, 12'h300, 5'd1, 32'h1, 5'd2, "umode_300");
    run_op(1'b0, 2'd3, 3'b001, 12'hF14, 5'd1, 32'h1, 5'd2, "ro_write");
    preset(12'hF14, 32'hA5A50001);
    run_op(1'b0, 2'd3, 3'b010, 12'hF14, 5'd0, 32'h0, 5'd1, "ro_read");
    run_op(1'b1, 2'd3, 3'b001, 12'h340, 5'd4, 32'hCAFEF00D, 5'd0, "sync_rw_rd0");
    run_op(1'b1, 2'd3, 3'b000, 12'h340, 5'd4, 32'h0, 5'd6, "f3_000");
    run_op(1'b0, 2'd1, 3'b100, 12'h100, 5'd4, 32'h0, 5'd6, "f3_100");
  endtask

  task automatic test_random();
    logic [1:0] p;
    for (int i = 0; i < 60; i++) begin
      p = 2'($urandom_range(0, 2));
      run_op(i[0], (p == 2'd2) ? 2'd3 : p, 3'($urandom_range(0, 7)), 12'($urandom),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic e_ready, e_re;
    sel = 1'b1;
    @(negedge clk);
    priviledge = 2'd3; req_funct3 = 3'b010; req_csr_addr = 12'h340;
    req_rs1_idx = 5'd0; req_rs1_data = 32'h0; req_rd_idx = 5'd2;
    req_valid1 = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      e_ready = (c == 4);
      e_re    = (c == 1) || (c == 5);
      compared += 2;
      if (o_ready !== e_ready) begin
        mismatched++; $display("FAIL b2b ready c%0d: got %b want %b", c, o_ready, e_ready);
      end
      if (o_re !== e_re) begin
        mismatched++; $display("FAIL b2b csr_re c%0d: got %b want %b", c, o_re, e_re);
      end
    end
    req_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (o_ready !== 1'b1) begin
      mismatched++; $display("FAIL b2b drain_ready: got %b want 1", o_ready);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] pre;
    pre = csr_mem[12'h340];
    sel = 1'b1;
    @(negedge clk);
    priviledge = 2'd3; req_funct3 = 3'b001; req_csr_addr = 12'h340;
    req_rs1_idx = 5'd9; req_rs1_data = ~pre; req_rd_idx = 5'd4;
    req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    compared += 3;
    if (o_we !== 1'b0 || o_wb !== 1'b0 || o_re !== 1'b0 || o_exc !== 1'b0) begin
      mismatched++; $display("FAIL rst_midop strobes: got we%b wb%b re%b exc%b want 0",
                             o_we, o_wb, o_re, o_exc);
    end
    if (o_ready !== 1'b1) begin
      mismatched++; $display("FAIL rst_midop ready: got %b want 1", o_ready);
    end
    if (o_addr !== 12'd0) begin
      mismatched++; $display("FAIL rst_midop addr: got %h want 000", o_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (csr_mem[12'h340] !== pre) begin
      mismatched++; $display("FAIL rst_midop no_write: got %h want %h", csr_mem[12'h340], pre);
    end
    run_op(1'b1, 2'd3, 3'b011, 12'h340, 5'd3, 32'h0000FFFF, 5'd8, "after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rv32_csr_access_unit.md
Name: rv32_csr_access_unit

Overview:
- Initiator side of the CSR register file interface. Executes Zicsr instructions (CSRRW/S/C and their immediate forms) handed over by the decode/execute stage.
- Checks privilege and read-only legality, then issues the read and write accesses to the CSR file.
- Returns the old CSR value for rd write-back, or raises an illegal-instruction exception.
- Sits between the execute stage and the CSR file; one instruction is in flight at a time.

Parameters:
- SYNC_READ, 0: 0 = CSR file read data is valid in the same cycle as csr_re; 1 = read data is valid one cycle after csr_re.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- priviledge  input  2  current privilege level (0 = U, 1 = S, 3 = M)
- req_valid  input  1  instruction offered
- req_ready  output  1  unit idle, can accept
- req_funct3  input  3  Zicsr funct3
- req_csr_addr  input  12  CSR address
- req_rs1_idx  input  5  rs1 field; also the zimm value
- req_rs1_data  input  32  rs1 register value
- req_rd_idx  input  5  destination register
- csr_addr  output  12  address to CSR file
- csr_re  output  1  read strobe
- csr_rdata  input  32  read data
- csr_we  output  1  write strobe
- csr_wdata  output  32  write data
- wb_valid  output  1  one-cycle rd write-back pulse
- wb_rd_idx  output  5  write-back register
- wb_data  output  32  old CSR value
- exc_illegal  output  1  one-cycle illegal-instruction pulse
- exc_tval  output  32  zero-extended {funct3, csr_addr} of the faulting op

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state is IDLE.
- FSM states: IDLE, READ, RWAIT (used only when SYNC_READ = 1), WRITE.
- req_ready = (state == IDLE). The request is accepted on req_valid & req_ready, and all req_* fields are latched.
- Legality is evaluated on the latched fields in READ. The instruction is illegal if any of the following holds:
  - funct3 is 000 or 100;
  - csr_addr[9:8] > priviledge;
  - csr_addr[11:10] == 2'b11 and a write is requested.
- A write is requested for: RW/RWI always; RS/RC/RSI/RCI only when rs1_idx != 0.
- Illegal instruction: in READ, pulse exc_illegal with exc_tval, assert no csr_re/csr_we and no wb_valid, then go to IDLE.
- READ (legal case):
  - csr_addr is driven with the latched address.
  - csr_re = 1 unless the op is RW/RWI with rd_idx == 0; in that case there is no read side-effect and the old value is taken as 0.
  - SYNC_READ = 0: capture csr_rdata this cycle and go to WRITE.
  - SYNC_READ = 1: go to RWAIT, capture csr_rdata there, then go to WRITE.
- Source operand: src = funct3[2] ? {27'b0, rs1_idx} : rs1_data.
- Write value: RW = src; RS = old | src; RC = old & ~src.
- WRITE: csr_we = write requested, csr_wdata = computed value, csr_addr is held. wb_valid = (rd_idx != 0), wb_data = old. Then go to IDLE.
- Latency from accept cycle N:
  - SYNC_READ = 0: csr_re at N+1, csr_we/wb at N+2, req_ready high again at N+3.
  - SYNC_READ = 1: csr_re at N+1, csr_we/wb at N+3, req_ready high at N+4.
- csr_re, csr_we, wb_valid and exc_illegal are never high outside their designated state. csr_re and csr_we are never high in the same cycle.
- rst mid-operation: on the next edge return to IDLE with all strobes low. No partial write may be issued after rst is sampled.
- req_valid while not ready is ignored; there is no queueing.

Decomposition:
- Package rv32_csr_pkg holds:
  - funct3 encodings: CSRRW = 001, CSRRS = 010, CSRRC = 011, and the immediate variants 101/110/111;
  - privilege constants PRIV_U/S/M;
  - the state enum;
  - the read-only field value 2'b11.
- Sub-module rv32_csr_legality_check (combinational): inputs funct3, addr, rs1_idx, priviledge; outputs illegal, write_req.

Test Plan:
1. M-mode, CSRRW addr 0x340, rs1_data 0xDEADBEEF, rd = 5, CSR holds 0x12345678 (SYNC_READ = 0) -> csr_re at N+1; csr_we with 0xDEADBEEF at N+2; wb_valid with rd 5, data 0x12345678 at N+2.
2. CSRRS addr 0x300, rs1 = 0, rd = 3, CSR holds 0x00001888 -> csr_re = 1, csr_we never asserted, wb_data = 0x00001888. Then CSRRCI zimm 0x8 on the same CSR -> csr_wdata = 0x00001880.
3. U-mode (priviledge = 0), CSRRS addr 0x300 -> exc_illegal pulse, exc_tval = 0x00002300, no csr_re/csr_we/wb_valid, req_ready back at N+2.
4. M-mode CSRRW to 0xF14 (read-only) -> exc_illegal. The same address with CSRRS rs1 = 0, rd = 1 -> legal read, wb_data = CSR value.
5. SYNC_READ = 1, CSRRW addr 0x340 rd = 0 -> csr_re never asserted, csr_we at N+3, no wb_valid. Back-to-back req_valid held high is accepted only at N+4.
6. Assert rst in the RWAIT/WRITE cycle -> no csr_we is observed, outputs are at reset values, req_ready = 1 on the following cycle. funct3 = 000 -> exc_illegal.
